acq_peak_search: RTL and testbench

- Downstream consumer of the non-coherent summation stage in the acquisition engine.
- Takes the stream of 9-bit non-coherent sums, one per code-phase/frequency bin, over one search round.
- Keeps the three largest values with their bin indices, accumulates a noise sum, and counts samples that flagged exceed.
- At round end it raises done for the acquisition controller, which uses the peaks for the detection decision and the exceed count for the next round's noncoh shift.

---
 rtl/acq_peak_search.sv | 171 +++++++++++++++++
 tb/tb_acq_peak_search.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_peak_search.sv
// acq_peak_search: keeps the three largest non-coherent sums of a search
// round with their bins, plus a saturating noise sum and exceed count.
//
// Ports:
//   clk, rst_b           clock, asynchronous active-low reset
//   start                one-cycle pulse: clear results, begin a round
//   data_valid, data_in  non-coherent sum stream (510 = saturated)
//   exceed_in            overflow flag, one cycle ahead of its sample
//   cor_index            code-phase bin of data_in
//   freq_index           frequency bin of data_in
//   last                 final sample of the round (qualified by data_valid)
//   peakN_amp/peakN_idx  top three peaks, descending, idx = {freq, cor}
//   noise_sum            saturating sum of accepted samples
//   exceed_cnt           saturating count of flagged accepted samples
//   busy                 round in progress
//   done                 one-cycle pulse, results final
module acq_peak_search #(
    parameter int COR_W   = 11,
    parameter int FREQ_W  = 5,
    parameter int NOISE_W = 24
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      start,
    input  logic                      data_valid,
    input  logic [8:0]                data_in,
    input  logic                      exceed_in,
    input  logic [COR_W-1:0]          cor_index,
    input  logic [FREQ_W-1:0]         freq_index,
    input  logic                      last,
    output logic [8:0]                peak1_amp,
    output logic [8:0]                peak2_amp,
    output logic [8:0]                peak3_amp,
    output logic [FREQ_W+COR_W-1:0]   peak1_idx,
    output logic [FREQ_W+COR_W-1:0]   peak2_idx,
    output logic [FREQ_W+COR_W-1:0]   peak3_idx,
    output logic [NOISE_W-1:0]        noise_sum,
    output logic [7:0]                exceed_cnt,
    output logic                      busy,
    output logic                      done
);

    localparam int IDX_W = FREQ_W + COR_W;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        FINISH
    } state_t;

    state_t state;

    // Flag arrives one cycle before its sample, so line it up here.
    logic exceed_d;

    logic [IDX_W-1:0] new_idx;
    logic             gt1;
    logic             gt2;
    logic             gt3;

    // One extra bit catches the carry out for saturation.
    logic [NOISE_W:0]   noise_add;
    logic [NOISE_W-1:0] noise_next;
    logic [7:0]         exceed_next;

    always_comb begin
        new_idx = {freq_index, cor_index};
        // Strict compare: on a tie the earlier bin stays ahead.
        gt1 = data_in > peak1_amp;
        gt2 = data_in > peak2_amp;
        gt3 = data_in > peak3_amp;
    end

    always_comb begin
        noise_add = {1'b0, noise_sum}
                  + {{(NOISE_W - 8){1'b0}}, data_in};
        if (noise_add[NOISE_W]) begin
            noise_next = '1;
        end else begin
            noise_next = noise_add[NOISE_W-1:0];
        end
    end

    always_comb begin
        exceed_next = exceed_cnt;
        if (exceed_d && exceed_cnt != 8'hFF) begin
            exceed_next = exceed_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            exceed_d <= 1'b0;
        end else begin
            exceed_d <= exceed_in;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= IDLE;
            peak1_amp  <= '0;
            peak2_amp  <= '0;
            peak3_amp  <= '0;
            peak1_idx  <= '0;
            peak2_idx  <= '0;
            peak3_idx  <= '0;
            noise_sum  <= '0;
            exceed_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // Start overrides everything, including a sample
                // presented in the same cycle.
                state      <= SEARCH;
                peak1_amp  <= '0;
                peak2_amp  <= '0;
                peak3_amp  <= '0;
                peak1_idx  <= '0;
                peak2_idx  <= '0;
                peak3_idx  <= '0;
                noise_sum  <= '0;
                exceed_cnt <= '0;
                busy       <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    SEARCH: begin
                        if (data_valid) begin
                            if (gt1) begin
                                peak3_amp <= peak2_amp;
                                peak3_idx <= peak2_idx;
                                peak2_amp <= peak1_amp;
                                peak2_idx <= peak1_idx;
                                peak1_amp <= data_in;
                                peak1_idx <= new_idx;
                            end else if (gt2) begin
                                peak3_amp <= peak2_amp;
                                peak3_idx <= peak2_idx;
                                peak2_amp <= data_in;
                                peak2_idx <= new_idx;
                            end else if (gt3) begin
                                peak3_amp <= data_in;
                                peak3_idx <= new_idx;
                            end
                            noise_sum  <= noise_next;
                            exceed_cnt <= exceed_next;
                            if (last) begin
                                state <= FINISH;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_peak_search.sv
// tb_acq_peak_search: directed rounds with hand-computed peaks;
// a monitor pops expected results on every done pulse.
module tb_acq_peak_search;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        start = 1'b0;
    logic        data_valid = 1'b0;
    logic [8:0]  data_in = '0;
    logic        exceed_in = 1'b0;
    logic [10:0] cor_index = '0;
    logic [4:0]  freq_index = '0;
    logic        last = 1'b0;

    logic [8:0]  peak1_amp, peak2_amp, peak3_amp;
    logic [15:0] peak1_idx, peak2_idx, peak3_idx;
    logic [23:0] noise_sum;
    logic [7:0]  exceed_cnt;
    logic        busy, done;

    logic [8:0]  s_p1a, s_p2a, s_p3a;
    logic [15:0] s_p1i, s_p2i, s_p3i;
    logic [11:0] s_noise;
    logic [7:0]  s_exc;
    logic        s_busy, s_done;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int a1, a2, a3;
        int i1, i2, i3;
        longint noise, noise_s;
        int exc;
    } exp_t;

    exp_t q[$];

    acq_peak_search dut (
        .clk(clk), .rst_b(rst_b), .start(start),
        .data_valid(data_valid), .data_in(data_in),
        .exceed_in(exceed_in), .cor_index(cor_index),
        .freq_index(freq_index), .last(last),
        .peak1_amp(peak1_amp), .peak2_amp(peak2_amp),
        .peak3_amp(peak3_amp), .peak1_idx(peak1_idx),
        .peak2_idx(peak2_idx), .peak3_idx(peak3_idx),
        .noise_sum(noise_sum), .exceed_cnt(exceed_cnt),
        .busy(busy), .done(done)
    );

    acq_peak_search #(.NOISE_W(12)) dut_s (
        .clk(clk), .rst_b(rst_b), .start(start),
        .data_valid(data_valid), .data_in(data_in),
        .exceed_in(exceed_in), .cor_index(cor_index),
        .freq_index(freq_index), .last(last),
        .peak1_amp(s_p1a), .peak2_amp(s_p2a),
        .peak3_amp(s_p3a), .peak1_idx(s_p1i),
        .peak2_idx(s_p2i), .peak3_idx(s_p3i),
        .noise_sum(s_noise), .exceed_cnt(s_exc),
        .busy(s_busy), .done(s_done)
    );

    always #5 clk = ~clk;

    function automatic int bi(input int f, input int c);
        return (f << 11) | c;
    endfunction

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected round.
    always @(negedge clk) begin
        if (rst_b && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("peak1_amp", peak1_amp, e.a1);
                chk("peak2_amp", peak2_amp, e.a2);
                chk("peak3_amp", peak3_amp, e.a3);
                chk("peak1_idx", peak1_idx, e.i1);
                chk("peak2_idx", peak2_idx, e.i2);
                chk("peak3_idx", peak3_idx, e.i3);
                chk("noise_sum", noise_sum, e.noise);
                chk("exceed_cnt", exceed_cnt, e.exc);
                chk("noise_sum_w12", s_noise, e.noise_s);
                chk("exceed_cnt_w12", s_exc, e.exc);
                chk("done_w12", s_done, 1);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ex);
        start = 1'b0;
        data_valid = 1'b0;
        last = 1'b0;
        exceed_in = ex;
        tick();
    endtask

    // exceed_in driven here belongs to the following sample.
    task automatic send(input int d, input int f, input int c,
                        input logic lst, input logic ex_next);
        data_valid = 1'b1;
        data_in = 9'(d);
        freq_index = 5'(f);
        cor_index = 11'(c);
        last = lst;
        exceed_in = ex_next;
        tick();
        data_valid = 1'b0;
        last = 1'b0;
    endtask

    task automatic begin_round;
        start = 1'b1;
        data_valid = 1'b0;
        exceed_in = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input int a1, input int i1, input int a2,
                        input int i2, input int a3, input int i3,
                        input longint n, input longint ns,
                        input int ex);
        exp_t e;
        e.a1 = a1; e.i1 = i1;
        e.a2 = a2; e.i2 = i2;
        e.a3 = a3; e.i3 = i3;
        e.noise = n; e.noise_s = ns; e.exc = ex;
        q.push_back(e);
    endtask

    task automatic wait_drain;
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            idle(1'b0);
        end
        chk("round_done_seen", q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_peak1_amp", peak1_amp, 0);
        chk("rst_peak1_idx", peak1_idx, 0);
        chk("rst_noise_sum", noise_sum, 0);
        chk("rst_exceed_cnt", exceed_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_b = 1'b1;
        idle(1'b0);

        // Round 1: ties keep the earlier bin.
        push(9, bi(0, 1), 9, bi(0, 3), 7, bi(0, 4), 33, 33, 0);
        begin_round();
        chk("busy_after_start", busy, 1);
        send(5, 0, 0, 0, 0);
        send(9, 0, 1, 0, 0);
        send(3, 0, 2, 0, 0);
        send(9, 0, 3, 0, 0);
        send(7, 0, 4, 1, 0);
        chk("done_after_last", done, 1);
        chk("busy_after_last", busy, 0);
        idle(1'b0);
        chk("done_one_cycle", done, 0);
        wait_drain();
        chk("hold_peak1_amp", peak1_amp, 9);

        // Round 2: ascending back-to-back.
        push(10, bi(2, 9), 9, bi(2, 8), 8, bi(2, 7), 55, 55, 0);
        begin_round();
        for (int k = 0; k < 10; k++) begin
            send(k + 1, 2, k, k == 9, 0);
        end
        wait_drain();

        // Round 3: three flagged samples plus one stray flag.
        push(8, bi(1, 1), 6, bi(1, 3), 4, bi(1, 0), 24, 24, 3);
        begin_round();
        idle(1'b1);
        send(4, 1, 0, 0, 0);
        send(8, 1, 1, 0, 1);
        send(2, 1, 2, 0, 0);
        send(6, 1, 3, 0, 1);
        idle(1'b0);
        send(1, 1, 4, 0, 1);
        send(3, 1, 5, 1, 0);
        wait_drain();

        // Round 4: saturation of both accumulators.
        push(510, bi(3, 0), 510, bi(3, 1), 510, bi(3, 2),
             153000, 4095, 255);
        begin_round();
        idle(1'b1);
        for (int k = 0; k < 300; k++) begin
            send(510, 3, k, k == 299, k != 299);
        end
        wait_drain();

        // Reset mid-round: no done, outputs cleared asynchronously.
        begin_round();
        send(100, 0, 0, 0, 1);
        send(101, 0, 1, 0, 1);
        send(102, 0, 2, 0, 1);
        send(103, 0, 3, 0, 0);
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst_peak1_amp", peak1_amp, 0);
        chk("arst_peak1_idx", peak1_idx, 0);
        chk("arst_noise_sum", noise_sum, 0);
        chk("arst_exceed_cnt", exceed_cnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_noise_w12", s_noise, 0);
        tick();
        rst_b = 1'b1;
        idle(1'b0);
        idle(1'b0);
        push(7, bi(0, 1), 5, bi(0, 2), 2, bi(0, 0), 14, 14, 0);
        begin_round();
        send(2, 0, 0, 0, 0);
        send(7, 0, 1, 0, 0);
        send(5, 0, 2, 1, 0);
        wait_drain();

        // Start collides with valid+last: start wins.
        push(7, bi(0, 5), 0, 0, 0, 0, 7, 7, 0);
        begin_round();
        send(20, 0, 0, 0, 0);
        start = 1'b1;
        data_valid = 1'b1;
        last = 1'b1;
        data_in = 9'd50;
        tick();
        start = 1'b0;
        data_valid = 1'b0;
        last = 1'b0;
        chk("collide_busy", busy, 1);
        chk("collide_done", done, 0);
        chk("collide_peak1", peak1_amp, 0);
        chk("collide_noise", noise_sum, 0);
        send(7, 0, 5, 1, 0);
        chk("collide_done_later", done, 1);
        wait_drain();

        idle(1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
